// File: rtl/onehot_route_dec.sv
// Registered, handshaked binary-to-one-hot router with an in-order tracking FIFO for responses.
// Optional decode-error path enabled by defining ONEHOT_ROUTE_DEC_ERR_EN.
module onehot_route_dec #(
    parameter int BIN_WIDTH  = 3,
    parameter int N_TARGETS  = 2**BIN_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    input  logic [BIN_WIDTH-1:0] in_bin_i,
    output logic                 in_ready_o,
    output logic [N_TARGETS-1:0] req_o,
    input  logic [N_TARGETS-1:0] tgt_gnt_i,
    input  logic [N_TARGETS-1:0] tgt_rvalid_i,
    output logic                 r_valid_o,
    output logic [N_TARGETS-1:0] r_sel_o,
    output logic                 r_err_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [N_TARGETS-1:0] onehot_f(input logic [BIN_WIDTH-1:0] bin);
        logic [N_TARGETS-1:0] vec;
        vec = {N_TARGETS{1'b0}};
        for (int i = 0; i < N_TARGETS; i++) begin
            if (bin == BIN_WIDTH'(i)) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("onehot_route_dec: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic in_err_s;
`ifdef ONEHOT_ROUTE_DEC_ERR_EN
    localparam logic [BIN_WIDTH:0] N_TGT_L = N_TARGETS[BIN_WIDTH:0];
    assign in_err_s = ({1'b0, in_bin_i} >= N_TGT_L);
`else
    // Without the error path every index must land on a real slave.
    generate
        if (N_TARGETS != 2**BIN_WIDTH) begin : g_bad_targets
            $error("onehot_route_dec: N_TARGETS must equal 2**BIN_WIDTH without ONEHOT_ROUTE_DEC_ERR_EN");
        end
    endgenerate
    assign in_err_s = 1'b0;
`endif

    logic                 busy_r;
    logic [N_TARGETS-1:0] sel_r;
    logic                 err_r;

    logic [N_TARGETS-1:0] fifo_sel_r [FIFO_DEPTH];
    logic                 fifo_err_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     cnt_r;

    logic                 r_valid_r;
    logic [N_TARGETS-1:0] r_sel_r;
    logic                 r_err_r;

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 gnt_hit_s;
    logic                 accept_s;
    logic                 pop_s;
    logic [N_TARGETS-1:0] head_sel_s;
    logic                 head_err_s;

    assign fifo_full_s  = (cnt_r == CNT_W'(FIFO_DEPTH));
    assign fifo_empty_s = (cnt_r == {CNT_W{1'b0}});

    // Error entries need no slave grant; a full FIFO blocks both issue and the push.
    assign gnt_hit_s  = busy_r & ~fifo_full_s & (err_r | (|(sel_r & tgt_gnt_i)));
    assign in_ready_o = ~busy_r | gnt_hit_s;
    assign accept_s   = in_valid_i & in_ready_o;
    assign req_o      = sel_r & {N_TARGETS{busy_r & ~err_r & ~fifo_full_s}};

    assign head_sel_s = fifo_sel_r[rd_ptr_r];
    assign head_err_s = fifo_err_r[rd_ptr_r];
    assign pop_s      = ~fifo_empty_s & (head_err_s | (|(head_sel_s & tgt_rvalid_i)));

    // Output stage: holds the pending request until it is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            sel_r  <= {N_TARGETS{1'b0}};
            err_r  <= 1'b0;
        end else if (accept_s) begin
            busy_r <= 1'b1;
            sel_r  <= onehot_f(in_bin_i);
            err_r  <= in_err_s;
        end else if (gnt_hit_s) begin
            busy_r <= 1'b0;
            sel_r  <= sel_r;
            err_r  <= err_r;
        end else begin
            busy_r <= busy_r;
            sel_r  <= sel_r;
            err_r  <= err_r;
        end
    end

    // In-order tracking FIFO of granted routes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_sel_r[i] <= {N_TARGETS{1'b0}};
                fifo_err_r[i] <= 1'b0;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (gnt_hit_s) begin
                fifo_sel_r[wr_ptr_r] <= sel_r;
                fifo_err_r[wr_ptr_r] <= err_r;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({gnt_hit_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Registered single-cycle response pulse steered by the FIFO head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_r <= 1'b0;
            r_sel_r   <= {N_TARGETS{1'b0}};
            r_err_r   <= 1'b0;
        end else if (pop_s) begin
            r_valid_r <= 1'b1;
            r_sel_r   <= head_sel_s;
            r_err_r   <= head_err_s;
        end else begin
            r_valid_r <= 1'b0;
            r_sel_r   <= {N_TARGETS{1'b0}};
            r_err_r   <= 1'b0;
        end
    end

    assign r_valid_o = r_valid_r;
    assign r_sel_o   = r_sel_r;
    assign r_err_o   = r_err_r;

endmodule

// File: tb/tb_onehot_route_dec.sv
// Directed self-checking bench for onehot_route_dec; exercises the error path when
// ONEHOT_ROUTE_DEC_ERR_EN is defined, otherwise the full power-of-two decode.
module tb_onehot_route_dec;

`ifdef ONEHOT_ROUTE_DEC_ERR_EN
    localparam int BW    = 3;
    localparam int NT    = 6;
    localparam int S_IDX = 5;
    localparam int O_IDX = 4;
`else
    localparam int BW    = 2;
    localparam int NT    = 4;
    localparam int S_IDX = 3;
    localparam int O_IDX = 2;
`endif
    localparam int FD = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [BW-1:0] in_bin;
    logic          in_ready;
    logic [NT-1:0] req;
    logic [NT-1:0] gnt;
    logic [NT-1:0] rvalid;
    logic          r_valid;
    logic [NT-1:0] r_sel;
    logic          r_err;

    int checks = 0;
    int errors = 0;

    onehot_route_dec #(.BIN_WIDTH(BW), .N_TARGETS(NT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_bin_i(in_bin),
        .in_ready_o(in_ready), .req_o(req), .tgt_gnt_i(gnt), .tgt_rvalid_i(rvalid),
        .r_valid_o(r_valid), .r_sel_o(r_sel), .r_err_o(r_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NT-1:0] oh(input int i);
        logic [NT-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_bin = '0; gnt = '0; rvalid = '0;
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", in_ready); end
        checks++; if (req !== '0) begin errors++; $display("FAIL reset_req: got %h exp 0", req); end
        checks++; if ({r_valid, r_err, r_sel} !== '0) begin errors++; $display("FAIL reset_resp: got v=%b e=%b s=%h exp 0", r_valid, r_err, r_sel); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_bin = BW'(S_IDX); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", in_ready); end
        tick(); in_valid = 1'b0; gnt = oh(S_IDX); #1;
        checks++; if (req !== oh(S_IDX)) begin errors++; $display("FAIL single_req: got %h exp %h", req, oh(S_IDX)); end
        tick(); gnt = '0; #1;
        checks++; if (req !== '0) begin errors++; $display("FAIL single_req_drop: got %h exp 0", req); end
        tick(); rvalid = oh(S_IDX); #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL single_no_early: got %b exp 0", r_valid); end
        tick(); rvalid = '0; #1;
        checks++; if (r_valid !== 1'b1 || r_sel !== oh(S_IDX) || r_err !== 1'b0) begin
            errors++; $display("FAIL single_resp: got v=%b s=%h e=%b exp v=1 s=%h e=0", r_valid, r_sel, r_err, oh(S_IDX)); end
        tick(); #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b exp 0", r_valid); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_bin = BW'(1); gnt = '0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b exp 1", in_ready); end
        tick(); in_bin = BW'(2); gnt = oh(1); #1;
        checks++; if (req !== oh(1) || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_c1: got req=%h rdy=%b exp req=%h rdy=1", req, in_ready, oh(1)); end
        tick(); in_bin = BW'(3); gnt = oh(2); #1;
        checks++; if (req !== oh(2) || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_c2: got req=%h rdy=%b exp req=%h rdy=1", req, in_ready, oh(2)); end
        tick(); in_valid = 1'b0; gnt = oh(3); #1;
        checks++; if (req !== '0 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_block: got req=%h rdy=%b exp req=0 rdy=0", req, in_ready); end
        tick(); rvalid = oh(1); #1;
        checks++; if (req !== '0) begin errors++; $display("FAIL b2b_full_hold: got %h exp 0", req); end
        tick(); rvalid = '0; #1;
        checks++; if (req !== oh(3) || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_reissue: got req=%h rdy=%b exp req=%h rdy=1", req, in_ready, oh(3)); end
        checks++; if (r_valid !== 1'b1 || r_sel !== oh(1)) begin errors++; $display("FAIL b2b_resp1: got v=%b s=%h exp v=1 s=%h", r_valid, r_sel, oh(1)); end
        tick(); gnt = '0; rvalid = oh(2); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b exp 1", in_ready); end
        tick(); rvalid = oh(3); #1;
        checks++; if (r_valid !== 1'b1 || r_sel !== oh(2)) begin errors++; $display("FAIL b2b_resp2: got v=%b s=%h exp v=1 s=%h", r_valid, r_sel, oh(2)); end
        tick(); rvalid = '0; #1;
        checks++; if (r_valid !== 1'b1 || r_sel !== oh(3)) begin errors++; $display("FAIL b2b_resp3_wrap: got v=%b s=%h exp v=1 s=%h", r_valid, r_sel, oh(3)); end
        tick();
    endtask

`ifdef ONEHOT_ROUTE_DEC_ERR_EN
    task automatic test_out_of_range();
        for (int b = 6; b <= 7; b++) begin
            in_valid = 1'b1; in_bin = BW'(b); #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL oor_ready bin=%0d: got %b exp 1", b, in_ready); end
            tick(); in_valid = 1'b0; #1;
            checks++; if (req !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL oor_noreq bin=%0d: got req=%h rdy=%b exp req=0 rdy=1", b, req, in_ready); end
            tick(); #1;
            checks++; if (req !== '0 || r_valid !== 1'b0) begin errors++; $display("FAIL oor_wait bin=%0d: got req=%h v=%b exp 0 0", b, req, r_valid); end
            tick(); #1;
            checks++; if (r_valid !== 1'b1 || r_err !== 1'b1 || r_sel !== '0) begin
                errors++; $display("FAIL oor_resp bin=%0d: got v=%b e=%b s=%h exp v=1 e=1 s=0", b, r_valid, r_err, r_sel); end
            tick(); #1;
            checks++; if (r_valid !== 1'b0 || r_err !== 1'b0) begin errors++; $display("FAIL oor_pulse bin=%0d: got v=%b e=%b exp 0 0", b, r_valid, r_err); end
        end
    endtask
`endif

    task automatic test_ordering();
        in_valid = 1'b1; in_bin = BW'(0); tick();
        in_bin = BW'(O_IDX); gnt = oh(0); tick();
        in_valid = 1'b0; gnt = oh(O_IDX); #1;
        checks++; if (req !== oh(O_IDX)) begin errors++; $display("FAIL order_req: got %h exp %h", req, oh(O_IDX)); end
        tick(); gnt = '0; rvalid = oh(O_IDX); tick();
        rvalid = oh(0); #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL order_early_ignored: got %b exp 0", r_valid); end
        tick(); rvalid = oh(O_IDX); #1;
        checks++; if (r_valid !== 1'b1 || r_sel !== oh(0)) begin errors++; $display("FAIL order_first: got v=%b s=%h exp v=1 s=%h", r_valid, r_sel, oh(0)); end
        tick(); rvalid = '0; #1;
        checks++; if (r_valid !== 1'b1 || r_sel !== oh(O_IDX)) begin errors++; $display("FAIL order_second: got v=%b s=%h exp v=1 s=%h", r_valid, r_sel, oh(O_IDX)); end
        tick(); #1;
        checks++; if (r_valid !== 1'b0) begin errors++; $display("FAIL order_done: got %b exp 0", r_valid); end
    endtask

    task automatic test_reset_mid_op();
        in_valid = 1'b1; in_bin = BW'(1); tick();
        in_bin = BW'(2); gnt = oh(1); tick();
        in_valid = 1'b0; gnt = '0; #1;
        checks++; if (req !== oh(2)) begin errors++; $display("FAIL rst_pre_req: got %h exp %h", req, oh(2)); end
        rst_n = 1'b0; #1;
        checks++; if (req !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_out: got req=%h rdy=%b exp req=0 rdy=1", req, in_ready); end
        checks++; if ({r_valid, r_err, r_sel} !== '0) begin errors++; $display("FAIL rst_mid_resp: got v=%b e=%b s=%h exp 0", r_valid, r_err, r_sel); end
        tick(); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rvalid = (c == 0) ? oh(1) : (c == 1) ? oh(2) : '0; #1;
            checks++; if (r_valid !== 1'b0 || req !== '0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL rst_discard c=%0d: got v=%b req=%h rdy=%b exp v=0 req=0 rdy=1", c, r_valid, req, in_ready); end
            tick();
        end
    endtask

    task automatic test_all_indices();
        for (int i = 0; i < NT; i++) begin
            in_valid = 1'b1; in_bin = BW'(i); tick();
            in_valid = 1'b0; gnt = oh(i); #1;
            checks++; if (req !== oh(i)) begin errors++; $display("FAIL all_req idx=%0d: got %h exp %h", i, req, oh(i)); end
            tick(); gnt = '0; rvalid = oh(i); tick();
            rvalid = '0; #1;
            checks++; if (r_valid !== 1'b1 || r_sel !== oh(i) || r_err !== 1'b0) begin
                errors++; $display("FAIL all_resp idx=%0d: got v=%b s=%h e=%b exp v=1 s=%h e=0", i, r_valid, r_sel, r_err, oh(i)); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifdef ONEHOT_ROUTE_DEC_ERR_EN
        test_out_of_range();
`endif
        test_ordering();
        test_reset_mid_op();
        test_all_indices();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
